// File: rtl/multi_mem_pkg.sv
// Shared widths and depths for the mixed-width frame RAM (8-bit write side, 16-bit read side).
package multi_mem_pkg;

  localparam int A_DATA_W   = 8;
  localparam int A_ADDR_W   = 12;
  localparam int B_DATA_W   = 16;
  localparam int B_ADDR_W   = 11;
  localparam int BANKS      = B_DATA_W / A_DATA_W;
  localparam int BANK_DEPTH = 1 << B_ADDR_W;

endpackage

// File: rtl/multi_mem_if.sv
// Bus bundle between the byte loader / pixel readout and multi_mem.
interface multi_mem_if
  import multi_mem_pkg::*;
(
  input logic clk
);

  logic [A_DATA_W-1:0] DataInA;
  logic [A_ADDR_W-1:0] AddressA;
  logic                ClockEnA;
  logic                WrA;
  logic                ResetA;
  logic [B_ADDR_W-1:0] AddressB;
  logic                ClockEnB;
  logic                ResetB;
  logic [B_DATA_W-1:0] QB;

  modport master (
    input  clk, QB,
    output DataInA, AddressA, ClockEnA, WrA, ResetA, AddressB, ClockEnB, ResetB
  );

  modport slave (
    input  clk, DataInA, AddressA, ClockEnA, WrA, ResetA, AddressB, ClockEnB, ResetB,
    output QB
  );

endinterface

// File: rtl/multi_mem_bank.sv
// One 2048x8 byte lane: synchronous write, registered read with hold, sync clear and async clear.
module multi_mem_bank
  import multi_mem_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [B_ADDR_W-1:0] wr_addr,
  input  logic [A_DATA_W-1:0] wr_data,
  input  logic                rd_en,
  input  logic                rd_clr,
  input  logic [B_ADDR_W-1:0] rd_addr,
  output logic [A_DATA_W-1:0] q
);

  logic [A_DATA_W-1:0] mem [BANK_DEPTH];

  // NOTE: storage has no reset branch so it maps onto block RAM; its zero contents come from configuration.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // NOTE: non-blocking read samples mem before this edge's write lands, giving read-before-write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      q <= '0;
    else if (rd_clr) q <= '0;
    else if (rd_en)  q <= mem[rd_addr];
  end

endmodule

// File: rtl/multi_mem.sv
// Mixed-width simple dual-port RAM: byte writes on port A, 16-bit word reads on port B.
module multi_mem
  import multi_mem_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [A_DATA_W-1:0] DataInA,
  input  logic [A_ADDR_W-1:0] AddressA,
  input  logic                ClockEnA,
  input  logic                WrA,
  input  logic                ResetA,
  input  logic [B_ADDR_W-1:0] AddressB,
  input  logic                ClockEnB,
  input  logic                ResetB,
  output logic [B_DATA_W-1:0] QB
);

  logic                wr_fire;
  logic [A_DATA_W-1:0] q_even;
  logic [A_DATA_W-1:0] q_odd;

  assign wr_fire = ClockEnA & WrA & ~ResetA;

  // Even byte addresses land in bank0 (QB low byte), odd ones in bank1 (QB high byte).
  multi_mem_bank bank0 (
    .clk     (clk),
    .rst_n   (reset),
    .we      (wr_fire & ~AddressA[0]),
    .wr_addr (AddressA[A_ADDR_W-1:1]),
    .wr_data (DataInA),
    .rd_en   (ClockEnB),
    .rd_clr  (ResetB),
    .rd_addr (AddressB),
    .q       (q_even)
  );

  multi_mem_bank bank1 (
    .clk     (clk),
    .rst_n   (reset),
    .we      (wr_fire & AddressA[0]),
    .wr_addr (AddressA[A_ADDR_W-1:1]),
    .wr_data (DataInA),
    .rd_en   (ClockEnB),
    .rd_clr  (ResetB),
    .rd_addr (AddressB),
    .q       (q_odd)
  );

  assign QB = {q_odd, q_even};

endmodule

// File: tb/tb_multi_mem.sv
// Directed bench for multi_mem: packing, read-before-write, enables, sync and async clears.
module tb_multi_mem;
  import multi_mem_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  multi_mem_if bus (.clk(clk));

  multi_mem dut (
    .clk      (clk),
    .reset    (reset),
    .DataInA  (bus.DataInA),
    .AddressA (bus.AddressA),
    .ClockEnA (bus.ClockEnA),
    .WrA      (bus.WrA),
    .ResetA   (bus.ResetA),
    .AddressB (bus.AddressB),
    .ClockEnB (bus.ClockEnB),
    .ResetB   (bus.ResetB),
    .QB       (bus.QB)
  );

  // Drive one edge's worth of inputs, take the edge, then settle 1 ns past it.
  task automatic cycle(input logic ena, input logic wra, input logic rsta,
                       input logic [11:0] aa, input logic [7:0] da,
                       input logic enb, input logic rstb, input logic [10:0] ab);
    bus.ClockEnA = ena;  bus.WrA = wra;  bus.ResetA = rsta;
    bus.AddressA = aa;   bus.DataInA = da;
    bus.ClockEnB = enb;  bus.ResetB = rstb; bus.AddressB = ab;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] aa, input logic [7:0] da);
    cycle(1'b1, 1'b1, 1'b0, aa, da, 1'b0, 1'b0, 11'h000);
  endtask

  task automatic rd(input logic [10:0] ab);
    cycle(1'b0, 1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0, ab);
  endtask

  task automatic test_reset;
    cycle(1'b0, 1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 11'h000);
    cycle(1'b0, 1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 11'h000);
    n_cmp++;
    if (bus.QB !== 16'h0000) begin
      $display("FAIL reset_qb: got %h expected %h", bus.QB, 16'h0000); n_fail++;
    end
    #2 reset = 1'b1;
  endtask

  task automatic test_basic;
    wr(12'hFFF, 8'h41);
    wr(12'hFFE, 8'h42);
    n_cmp++;
    if (bus.QB !== 16'h0000) begin
      $display("FAIL basic_no_read: got %h expected %h", bus.QB, 16'h0000); n_fail++;
    end
    rd(11'h7FF);
    n_cmp++;
    if (bus.QB !== 16'h4142) begin
      $display("FAIL basic_read: got %h expected %h", bus.QB, 16'h4142); n_fail++;
    end
  endtask

  task automatic test_overwrite;
    wr(12'hFFF, 8'h43);
    rd(11'h7FF);
    n_cmp++;
    if (bus.QB !== 16'h4342) begin
      $display("FAIL overwrite: got %h expected %h", bus.QB, 16'h4342); n_fail++;
    end
  endtask

  task automatic test_back_to_back;
    cycle(1'b1, 1'b1, 1'b0, 12'hFFF, 8'h44, 1'b1, 1'b0, 11'h7FF);
    n_cmp++;
    if (bus.QB !== 16'h4342) begin
      $display("FAIL rdw_1: got %h expected %h", bus.QB, 16'h4342); n_fail++;
    end
    cycle(1'b1, 1'b1, 1'b0, 12'hFFE, 8'h45, 1'b1, 1'b0, 11'h7FF);
    n_cmp++;
    if (bus.QB !== 16'h4442) begin
      $display("FAIL rdw_2: got %h expected %h", bus.QB, 16'h4442); n_fail++;
    end
    cycle(1'b1, 1'b1, 1'b0, 12'hFFE, 8'h46, 1'b1, 1'b0, 11'h7FF);
    n_cmp++;
    if (bus.QB !== 16'h4445) begin
      $display("FAIL rdw_3: got %h expected %h", bus.QB, 16'h4445); n_fail++;
    end
    rd(11'h7FF);
    n_cmp++;
    if (bus.QB !== 16'h4446) begin
      $display("FAIL rdw_final: got %h expected %h", bus.QB, 16'h4446); n_fail++;
    end
  endtask

  task automatic test_mid_range;
    wr(12'h7FF, 8'h5A);
    wr(12'h7FE, 8'h59);
    wr(12'h7FE, 8'h52);
    rd(11'h3FF);
    n_cmp++;
    if (bus.QB !== 16'h5A52) begin
      $display("FAIL mid_read: got %h expected %h", bus.QB, 16'h5A52); n_fail++;
    end
    rd(11'h7FF);
    n_cmp++;
    if (bus.QB !== 16'h4446) begin
      $display("FAIL mid_top_intact: got %h expected %h", bus.QB, 16'h4446); n_fail++;
    end
  endtask

  task automatic test_enables;
    cycle(1'b0, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0, 11'h3FF);
    n_cmp++;
    if (bus.QB !== 16'h4446) begin
      $display("FAIL hold_enb0: got %h expected %h", bus.QB, 16'h4446); n_fail++;
    end
    cycle(1'b0, 1'b1, 1'b0, 12'hFFF, 8'h00, 1'b0, 1'b0, 11'h000);
    cycle(1'b1, 1'b1, 1'b1, 12'hFFE, 8'h00, 1'b0, 1'b0, 11'h000);
    rd(11'h7FF);
    n_cmp++;
    if (bus.QB !== 16'h4446) begin
      $display("FAIL write_inhibit: got %h expected %h", bus.QB, 16'h4446); n_fail++;
    end
    cycle(1'b0, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 1'b1, 11'h7FF);
    n_cmp++;
    if (bus.QB !== 16'h0000) begin
      $display("FAIL resetb_clear: got %h expected %h", bus.QB, 16'h0000); n_fail++;
    end
    rd(11'h3FF);
    n_cmp++;
    if (bus.QB !== 16'h5A52) begin
      $display("FAIL reread_mid: got %h expected %h", bus.QB, 16'h5A52); n_fail++;
    end
    // ResetB must win over an active read enable.
    cycle(1'b0, 1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 1'b1, 11'h7FF);
    n_cmp++;
    if (bus.QB !== 16'h0000) begin
      $display("FAIL resetb_priority: got %h expected %h", bus.QB, 16'h0000); n_fail++;
    end
  endtask

  task automatic test_async_reset;
    rd(11'h7FF);
    #3 reset = 1'b0;
    #1;
    n_cmp++;
    if (bus.QB !== 16'h0000) begin
      $display("FAIL async_clear: got %h expected %h", bus.QB, 16'h0000); n_fail++;
    end
    // Write during reset, then another write on the release edge.
    bus.ClockEnA = 1'b1; bus.WrA = 1'b1; bus.ResetA = 1'b0;
    bus.AddressA = 12'h000; bus.DataInA = 8'h11;
    bus.ClockEnB = 1'b0; bus.ResetB = 1'b0;
    @(posedge clk);
    #1;
    bus.AddressA = 12'h001; bus.DataInA = 8'h22;
    #3 reset = 1'b1;
    @(posedge clk);
    #1;
    rd(11'h000);
    n_cmp++;
    if (bus.QB !== 16'h2211) begin
      $display("FAIL reset_edge_write: got %h expected %h", bus.QB, 16'h2211); n_fail++;
    end
    rd(11'h7FF);
    n_cmp++;
    if (bus.QB !== 16'h4446) begin
      $display("FAIL post_reset_read: got %h expected %h", bus.QB, 16'h4446); n_fail++;
    end
  endtask

  initial begin
    bus.DataInA = '0; bus.AddressA = '0; bus.ClockEnA = 1'b0; bus.WrA = 1'b0;
    bus.ResetA = 1'b0; bus.AddressB = '0; bus.ClockEnB = 1'b0; bus.ResetB = 1'b0;
    test_reset();
    test_basic();
    test_overwrite();
    test_back_to_back();
    test_mid_range();
    test_enables();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
